// File: rtl/ps2_keyboard_tx_if.sv
// Scancode push port plus generated PS/2 lines of the keyboard emulator.
// PS2_TX_PARITY_INJ_EN adds the per-byte parity-error injection input.
`timescale 1ns/1ps
interface ps2_keyboard_tx_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
`ifdef PS2_TX_PARITY_INJ_EN
   logic       inj_par_err;
`endif

   modport master (
`ifdef PS2_TX_PARITY_INJ_EN
      output inj_par_err,
`endif
      output in_data, in_valid,
      input  in_ready, ps2_clk, ps2_data, busy
   );

   modport slave (
`ifdef PS2_TX_PARITY_INJ_EN
      input  inj_par_err,
`endif
      input  in_data, in_valid,
      output in_ready, ps2_clk, ps2_data, busy
   );
endinterface

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: scancode FIFO feeding an 11-bit frame serialiser.
// Optional PS2_TX_PARITY_INJ_EN stores an inject flag per byte that inverts the frame parity.
`timescale 1ns/1ps
module ps2_keyboard_tx #(
   parameter int unsigned CLK_DIV    = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = 32
) (
   input  logic               clk,
   input  logic               resetn,
   ps2_keyboard_tx_if.slave   bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
`ifdef PS2_TX_PARITY_INJ_EN
   localparam int unsigned ENT_W = 9;
`else
   localparam int unsigned ENT_W = 8;
`endif

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [3:0]         idx_q, idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [10:0]        shreg_q, shreg_d;
   logic               ps2_clk_q, ps2_clk_d;
   logic               ps2_data_q, ps2_data_d;
   logic               busy_q, busy_d;
   logic               in_ready_q, in_ready_d;

   logic               push, pop;
   logic [ENT_W-1:0]   entry_in, head;
   logic [7:0]         head_data;
   logic               head_par;

   // in_ready_q already mirrors !full, so a push into a full FIFO cannot happen
   assign push = bus.in_valid & in_ready_q;
   assign pop  = (state_q == S_LOAD);
   assign head = fifo_q[rd_ptr_q];
   assign head_data = head[7:0];

`ifdef PS2_TX_PARITY_INJ_EN
   assign entry_in = {bus.inj_par_err, bus.in_data};
   assign head_par = (~^head_data) ^ head[8];
`else
   assign entry_in = bus.in_data;
   assign head_par = ~^head_data;
`endif

   assign bus.in_ready = in_ready_q;
   assign bus.ps2_clk  = ps2_clk_q;
   assign bus.ps2_data = ps2_data_q;
   assign bus.busy     = busy_q;

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= entry_in;
   end

   // Next-state and registered-output computation; outputs lag the divider by one clock
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      shreg_d    = shreg_q;
      ps2_clk_d  = 1'b1;
      ps2_data_d = 1'b1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) state_d = S_LOAD;
         end
         S_LOAD: begin
            shreg_d = {1'b1, head_par, head_data, 1'b0};
            div_d   = '0;
            idx_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            ps2_data_d = shreg_q[0];
            ps2_clk_d  = (div_q < DIV_W'(CLK_DIV));
            if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
               div_d   = '0;
               shreg_d = {1'b1, shreg_q[10:1]};
               if (idx_q == 4'd10) begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
            else                                gap_d   = gap_q + GAP_W'(1);
         end
      endcase

      in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
      busy_d     = (count_d != '0) || (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         div_q      <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         shreg_q    <= '1;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         shreg_q    <= shreg_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx with a host-side PS/2 decoder sampling on falling ps2_clk.
// Build with PS2_TX_PARITY_INJ_EN defined to also exercise parity injection.
`timescale 1ns/1ps
module tb_ps2_keyboard_tx;

   localparam int unsigned CDIV  = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned GAP   = 32;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   ps2_keyboard_tx_if bus ();

   ps2_keyboard_tx #(.CLK_DIV(CDIV), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Host model: collects 11 bits on falling ps2_clk, decodes, records timing
   logic [7:0]  rxq [$];
   int          gaps [$];
   logic [10:0] fr, last_fr;
   int          nbits = 0, n_falls = 0, n_par_err = 0, n_frm_err = 0;
   logic        prev_clk = 1'b1, prev_data = 1'b1, have_frame = 1'b0;
   time         start_t = 0, rise_t = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            nbits      = 0;
            have_frame = 1'b0;
         end else begin
            if (nbits == 0 && prev_data && !bus.ps2_data) begin
               start_t = $time - 5;
               if (have_frame) gaps.push_back(int'((start_t - rise_t) / 10));
            end
            if (prev_clk && !bus.ps2_clk) begin
               fr[nbits] = bus.ps2_data;
               nbits++;
               n_falls++;
               if (nbits == 11) begin
                  last_fr = fr;
                  rxq.push_back(fr[8:1]);
                  if (fr[0] != 1'b0 || fr[10] != 1'b1) n_frm_err++;
                  if (^fr[9:1] != 1'b1) n_par_err++;
                  nbits      = 0;
                  have_frame = 1'b1;
               end
            end
            if (!prev_clk && bus.ps2_clk) rise_t = $time - 5;
         end
         prev_clk  = bus.ps2_clk;
         prev_data = bus.ps2_data;
      end
   end

   time acc_t;

   // Leaves in_valid high after the accepting edge so consecutive calls stream
   task automatic push(input logic [7:0] d, input logic inj);
      int k = 0;
      @(negedge clk);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
`ifdef PS2_TX_PARITY_INJ_EN
      bus.inj_par_err = inj;
`else
      if (inj) $display("note: injection requested but feature not built");
`endif
      while (!bus.in_ready && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) check("push_timeout", 32'(k), 32'(0));
      @(posedge clk);
      acc_t = $time;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      int k = 0;
      while (rxq.size() < n && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("rx_count", 32'(rxq.size()), 32'(n));
   endtask

   task automatic wait_idle();
      int k = 0;
      while (bus.busy && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("idle_busy", 32'(bus.busy), 32'(0));
   endtask

   task automatic wait_clk_high();
      int k = 0;
      while (!bus.ps2_clk && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("wait_clk_rise", 32'(bus.ps2_clk), 32'(1));
   endtask

   logic [7:0] stream [6];
   int base, falls0;

   initial begin
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
`ifdef PS2_TX_PARITY_INJ_EN
      bus.inj_par_err = 1'b0;
`endif
      // Reset state while held
      repeat (3) @(negedge clk);
      check("rst_ps2_clk",  32'(bus.ps2_clk),  32'(1));
      check("rst_ps2_data", 32'(bus.ps2_data), 32'(1));
      check("rst_busy",     32'(bus.busy),     32'(0));
      check("rst_in_ready", 32'(bus.in_ready), 32'(0));
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(bus.in_ready), 32'(1));

      // 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 and start bit at edge t+3
      push(8'h1C, 1'b0);
      idle();
      check("busy_during", 32'(bus.busy), 32'(1));
      wait_rx(1);
      check("rx_1c",      32'(rxq[0]),  32'h1C);
      check("frame_1c",   32'(last_fr), 32'h438);
      check("latency",    32'((start_t - acc_t) / 10), 32'(3));
      wait_idle();
      check("falls_1c",   32'(n_falls), 32'(11));

      // Parity of 0x00 and 0xFF is 1
      push(8'h00, 1'b0);
      idle();
      wait_rx(2);
      check("frame_00", 32'(last_fr), 32'h600);
      push(8'hFF, 1'b0);
      idle();
      wait_rx(3);
      check("frame_ff", 32'(last_fr), 32'h7FE);
      check("rx_00", 32'(rxq[1]), 32'h00);
      check("rx_ff", 32'(rxq[2]), 32'hFF);
      wait_idle();

      // Six bytes streamed: ready drops after five accepts, order and gaps preserved
      stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      base = rxq.size();
      gaps.delete();
      for (int i = 0; i < 5; i++) push(stream[i], 1'b0);
      #1 check("ready_full", 32'(bus.in_ready), 32'(0));
      push(stream[5], 1'b0);
      idle();
      wait_rx(base + 6);
      for (int i = 0; i < 6; i++) check($sformatf("stream%0d", i), 32'(rxq[base + i]), 32'(stream[i]));
      check("gap_count", 32'(gaps.size()), 32'(6));
      for (int i = 1; i < 6 && i < gaps.size(); i++)
         check($sformatf("gap%0d", i), 32'(gaps[i]), 32'(GAP + 2));
      wait_idle();

      // Push coinciding with the pop of the queued byte keeps the count at 1
      stream = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      base = rxq.size();
      push(stream[0], 1'b0);
      push(stream[1], 1'b0);
      idle();
      wait_rx(base + 1);
      wait_clk_high();
      repeat (GAP - 1) @(negedge clk);
      push(stream[2], 1'b0);
      check("pp_align", 32'((acc_t - rise_t) / 10), 32'(GAP + 1));
      #1 check("pp_ready", 32'(bus.in_ready), 32'(1));
      push(stream[3], 1'b0);
      push(stream[4], 1'b0);
      #1 check("pp_ready3", 32'(bus.in_ready), 32'(1));
      push(stream[5], 1'b0);
      #1 check("pp_full", 32'(bus.in_ready), 32'(0));
      idle();
      wait_rx(base + 6);
      for (int i = 0; i < 6; i++) check($sformatf("pp_order%0d", i), 32'(rxq[base + i]), 32'(stream[i]));
      wait_idle();

      // Reset during data bit 4 of 0x0F (d4=0, so ps2_data is low when reset hits)
      base = rxq.size();
      push(8'h0F, 1'b0);
      idle();
      for (int k = 0; k < 2000 && nbits < 5; k++) @(negedge clk);
      check("wait_bit5", 32'(nbits), 32'(5));
      wait_clk_high();
      check("pre_rst_data", 32'(bus.ps2_data), 32'(0));
      resetn = 1'b0;
      @(negedge clk);
      check("mid_rst_clk",   32'(bus.ps2_clk),  32'(1));
      check("mid_rst_data",  32'(bus.ps2_data), 32'(1));
      check("mid_rst_busy",  32'(bus.busy),     32'(0));
      check("mid_rst_ready", 32'(bus.in_ready), 32'(0));
      falls0 = n_falls;
      @(negedge clk);
      resetn = 1'b1;
      repeat (300) @(negedge clk);
      check("no_falls_after", 32'(n_falls), 32'(falls0));
      check("no_partial_rx",  32'(rxq.size()), 32'(base));
      push(8'h5A, 1'b0);
      idle();
      wait_rx(base + 1);
      check("rx_5a",    32'(rxq[base]), 32'h5A);
      check("frame_5a", 32'(last_fr),   32'h6B4);
      wait_idle();

`ifdef PS2_TX_PARITY_INJ_EN
      // Injected parity error on one byte only
      base = rxq.size();
      push(8'h1C, 1'b1);
      push(8'h1C, 1'b0);
      idle();
      wait_rx(base + 1);
      check("inj_frame", 32'(last_fr), 32'h638);
      check("inj_par_err", 32'(n_par_err), 32'(1));
      wait_rx(base + 2);
      check("inj_next_frame", 32'(last_fr), 32'h438);
      check("inj_par_err_total", 32'(n_par_err), 32'(1));
      wait_idle();
`else
      check("par_err_total", 32'(n_par_err), 32'(0));
`endif
      check("frame_errs", 32'(n_frm_err), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
